// File: rtl/tiny16_pkg.sv
// tiny16_pkg: constants shared by the tiny16 bus fabric and its users.
//   WIDTH_DEFAULT : default bus data width
//   SRC_*         : source index assignment on the fabric
package tiny16_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  localparam int unsigned SRC_MEM  = 0;
  localparam int unsigned SRC_REG  = 1;
  localparam int unsigned SRC_ALU  = 2;
  localparam int unsigned SRC_CTRL = 3;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter with an external keep override.
//   req    : per-source request
//   last   : most recent owner; search starts at last+1 with wrap-around
//   keep   : current owner (== last) keeps the bus this cycle
//   winner : selected source index
//   any    : a source was selected
module rr_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned OW      = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [OW-1:0]      last,
  input  logic               keep,
  output logic [OW-1:0]      winner,
  output logic               any
);

  int unsigned idx;
  logic [OW-1:0] sel;

  // First requester strictly after last, visiting last itself at the end
  always_comb begin
    winner = last;
    any    = 1'b0;
    idx    = 0;
    sel    = '0;
    if (keep) begin
      any = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
        idx = (32'(last) + k) % NUM_SRC;
        sel = OW'(idx);
        if (!any && req[sel]) begin
          any    = 1'b1;
          winner = sel;
        end
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: registered, round-robin arbitrated bus multiplexer with bounded lock.
//   clk, rst   : clock, asynchronous active-low reset
//   req, lock  : per-source request / keep-ownership request
//   src_data   : source i at [i*WIDTH +: WIDTH]
//   gnt, owner : registered one-hot grant and owner index
//   bus        : registered bus value (holds while idle)
//   bus_valid  : bus carries data granted this cycle
//   xfer_cnt, stall_cnt : saturating monitor counters, only with BUS_MONITOR_EN
module bus_fabric
  import tiny16_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned MAX_LOCK  = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [NUM_SRC-1:0]         lock,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  output logic [NUM_SRC-1:0]         gnt,
  output logic [$clog2(NUM_SRC)-1:0] owner,
  output logic [WIDTH-1:0]           bus,
  output logic                       bus_valid
`ifdef BUS_MONITOR_EN
  ,
  output logic [CNT_WIDTH-1:0]       xfer_cnt,
  output logic [CNT_WIDTH-1:0]       stall_cnt
`endif
);

  localparam int unsigned OW = $clog2(NUM_SRC);
  localparam int unsigned LW = $clog2(MAX_LOCK + 1);

  if (WIDTH < 8 || NUM_SRC < 2 || NUM_SRC > 8 || MAX_LOCK < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("bus_fabric: parameter out of range");
  end

  logic [OW-1:0]      last;
  logic [LW-1:0]      lock_cnt;
  logic               keep_c;
  logic [OW-1:0]      winner_c;
  logic               any_c;
  logic [NUM_SRC-1:0] gnt_c;
  logic [WIDTH-1:0]   src_arr [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign src_arr[i] = src_data[i*WIDTH +: WIDTH];
  end

  // Keep only while a grant is live, so a stale owner after idle/reset cannot lock
  assign keep_c = bus_valid && req[owner] && lock[owner] && (lock_cnt < LW'(MAX_LOCK));

  rr_arbiter #(.NUM_SRC(NUM_SRC), .OW(OW)) u_arb (
    .req    (req),
    .last   (last),
    .keep   (keep_c),
    .winner (winner_c),
    .any    (any_c)
  );

  assign gnt_c = any_c ? (NUM_SRC'(1) << winner_c) : '0;

  // Grant, data and lock-count registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      owner     <= '0;
      bus       <= '0;
      bus_valid <= 1'b0;
      last      <= OW'(NUM_SRC - 1);
      lock_cnt  <= '0;
    end else if (any_c) begin
      gnt       <= gnt_c;
      owner     <= winner_c;
      bus       <= src_arr[winner_c];
      bus_valid <= 1'b1;
      last      <= winner_c;
      lock_cnt  <= keep_c ? lock_cnt + LW'(1) : LW'(1);
    end else begin
      gnt       <= '0;
      bus_valid <= 1'b0;
      lock_cnt  <= '0;
    end
  end

`ifdef BUS_MONITOR_EN
  // Saturating transfer / stall counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (any_c && xfer_cnt != '1)
        xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
      if (|(req & ~gnt_c) && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
